pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the program counter and drives instruction fetch for the 8-bit processor.
//  It is the consumer end of the next-PC interface: it holds currPC and applies the
//  sequential/branch/jump rule when the pipeline advances.
//  It runs a req/ack handshake to instruction memory and presents one fetched
//  instruction at a time to decode.
// PARAMETERS
//  MIPS_PC_WIDTH_m1  7   PC msb index (PC is 8 bits)
//  INSTR_WIDTH       8   instruction word width
//  RAS_DEPTH         4   return-address stack entries (RAS_EN only; power of 2)
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous active-low reset
//  PCSrc        in   1   branch taken, sampled on advance
//  jump         in   1   jump, sampled on advance
//  databus      in   8   branch/jump target field, sampled on advance
//  call         in   1   call; ignored without RAS_EN
//  ret          in   1   return; ignored without RAS_EN
//  advance      in   1   decode consumed instr this cycle
//  imem_ack     in   1   instruction memory returns imem_data this cycle
//  imem_data    in   INSTR_WIDTH  fetched word
//  imem_req     out  1   fetch request
//  imem_addr    out  8   fetch address (= currPC)
//  instr        out  INSTR_WIDTH  held instruction
//  instr_valid  out  1   instr valid for decode
//  currPC       out  8   PC of instr / current fetch
//  ras_err      out  1   one-cycle pulse: RAS over/underflow
// BEHAVIOUR
//  Reset (async, immediate): currPC=0x00, imem_req=0, instr=0, instr_valid=0,
//   ras_err=0, RAS pointer/count=0, state=FETCH. Reset mid-handshake drops
//   imem_req at once; fetch restarts from 0x00.
//  FSM states: FETCH, HOLD.
//   FETCH: imem_req=1, imem_addr=currPC; addr and req stable until imem_ack.
//    imem_ack=1 -> register imem_data into instr; instr_valid=1 next cycle;
//    imem_req=0 next cycle; go to HOLD. Ack in the first req cycle is legal.
//   HOLD: instr, instr_valid and currPC stay stable.
//    advance=1 -> currPC<=next PC; instr_valid=0; go to FETCH.
//   imem_ack outside FETCH is ignored. advance outside HOLD is ignored.
//  Next-PC rule, evaluated in the advance cycle; priority is top-down:
//   ret (RAS_EN)           -> popped address
//   call (RAS_EN) or jump  -> {currPC[7:5], databus[4:0]}
//   PCSrc                  -> {currPC[7:3], databus[2:0]}
//   otherwise              -> currPC+1, mod 256 (0xFF -> 0x00)
//  Latency: advance at cycle N -> imem_req high at N+1.
//   With a zero-wait ack, instr_valid returns at N+2.
// CONFIGURATION
//  PC_FETCH_RAS_EN defined: RAS_DEPTH-entry circular return-address stack.
//   call+advance: push currPC+1 (wraps mod 256).
//   Push while full overwrites the oldest entry and pulses ras_err.
//   ret+advance: pop into PC.
//   ret on an empty stack: PC=currPC+1 and ras_err pulses.
//   call and ret together: ret wins, no push.
//  Not defined: call and ret are ignored; ras_err is tied to 0; no stack storage.
// TESTING
//  1 Reset release, ack 1 cycle after each req, advance each HOLD
//    -> imem_addr 00,01,02,...; after FF it wraps to 00.
//  2 currPC=0x2A, advance, PCSrc=1, databus=0x05 -> next imem_addr=0x2D.
//  3 currPC=0xC4, advance, jump=1, PCSrc=1, databus=0x1F -> next imem_addr=0xDF.
//  4 imem_ack delayed 3 cycles -> imem_req/imem_addr held stable all 3 cycles;
//    instr_valid only after ack.
//  5 reset_n low during FETCH wait -> imem_req=0 immediately;
//    after release, fetch addr=0x00.
//  6 RAS_EN: call@0x10 (databus=0x08) -> PC=0x08; ret -> PC=0x11;
//    5 pushes on 4-deep stack -> ras_err pulse; ret when empty -> PC+1, ras_err.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end for the 8-bit processor.
// Optional return-address stack enabled by defining PC_FETCH_RAS_EN.
module pc_fetch_unit #(
    parameter int MIPS_PC_WIDTH_m1 = 7,
    parameter int INSTR_WIDTH      = 8,
    parameter int RAS_DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      PCSrc,
    input  logic                      jump,
    input  logic [7:0]                databus,
    input  logic                      call,
    input  logic                      ret,
    input  logic                      advance,
    input  logic                      imem_ack,
    input  logic [INSTR_WIDTH-1:0]    imem_data,
    output logic                      imem_req,
    output logic [MIPS_PC_WIDTH_m1:0] imem_addr,
    output logic [INSTR_WIDTH-1:0]    instr,
    output logic                      instr_valid,
    output logic [MIPS_PC_WIDTH_m1:0] currPC,
    output logic                      ras_err
);

    localparam int PCW = MIPS_PC_WIDTH_m1 + 1;

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t         state;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] next_pc;
    logic           ras_fault;
    logic           take_adv;
    logic           unused;

    assign pc_inc    = currPC + PCW'(1);
    assign imem_addr = currPC;
    assign take_adv  = (state == HOLD) && advance;

`ifdef PC_FETCH_RAS_EN
    localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RAS_AW:0] CNT_FULL = RAS_DEPTH[RAS_AW:0];

    logic [PCW-1:0]  ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_ptr;
    logic [RAS_AW:0]   ras_cnt;
    logic [PCW-1:0]  ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            do_push;
    logic            do_pop;

    // ras_ptr points at the next free slot; the top entry sits just below it.
    assign ras_top   = ras_mem[ras_ptr - RAS_AW'(1)];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_FULL);
    assign unused    = &{1'b0, databus[7:5]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_pc   = pc_inc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ras_fault = 1'b0;
        if (ret) begin
            if (ras_empty) begin
                ras_fault = 1'b1;
            end else begin
                do_pop  = 1'b1;
                next_pc = ras_top;
            end
        end else if (call || jump) begin
            next_pc   = {currPC[PCW-1:5], databus[4:0]};
            do_push   = call;
            ras_fault = call && ras_full;
        end else if (PCSrc) begin
            next_pc = {currPC[PCW-1:3], databus[2:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (take_adv) begin
            if (do_pop) begin
                ras_ptr <= ras_ptr - RAS_AW'(1);
                ras_cnt <= ras_cnt - (RAS_AW + 1)'(1);
            end else if (do_push) begin
                ras_ptr <= ras_ptr + RAS_AW'(1);
                if (!ras_full)
                    ras_cnt <= ras_cnt + (RAS_AW + 1)'(1);
            end
        end
    end

    // NOTE: stack storage has no reset; ras_cnt guarantees no entry is read before it is written.
    always_ff @(posedge clk) begin
        if (take_adv && do_push)
            ras_mem[ras_ptr] <= pc_inc;
    end
`else
    assign unused = &{1'b0, databus[7:5], call, ret, RAS_DEPTH[0]};

    always_comb begin
        next_pc   = pc_inc;
        ras_fault = 1'b0;
        if (jump)
            next_pc = {currPC[PCW-1:5], databus[4:0]};
        else if (PCSrc)
            next_pc = {currPC[PCW-1:3], databus[2:0]};
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            currPC      <= '0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            ras_err     <= 1'b0;
        end else begin
            ras_err <= 1'b0;
            case (state)
                FETCH: begin
                    // An ack only counts while a request is actually outstanding.
                    if (imem_req && imem_ack) begin
                        instr       <= imem_data;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        currPC      <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        ras_err     <= ras_fault;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
// Return-address-stack scenarios run when PC_FETCH_RAS_EN is defined.
module tb_pc_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       PCSrc, jump, call, ret, advance, imem_ack;
    logic [7:0] databus, imem_data;
    logic       imem_req, instr_valid, ras_err;
    logic [7:0] imem_addr, instr, currPC;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_pc;
    logic [7:0] last_instr;

    pc_fetch_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCSrc      (PCSrc),
        .jump       (jump),
        .databus    (databus),
        .call       (call),
        .ret        (ret),
        .advance    (advance),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .currPC     (currPC),
        .ras_err    (ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, hold ack off for wait_cyc cycles, then return data.
    task automatic do_fetch(input logic [7:0] exp_addr, input int wait_cyc, input logic [7:0] data);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req", imem_req, 1);
        check("addr", imem_addr, exp_addr);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            check("req_hold", imem_req, 1);
            check("addr_hold", imem_addr, exp_addr);
            check("valid_early", instr_valid, 0);
        end
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
        check("valid", instr_valid, 1);
        check("instr", instr, data);
        check("req_drop", imem_req, 0);
        last_instr = data;
    endtask

    task automatic do_advance(input logic pcs, input logic jmp, input logic cl, input logic rt,
                              input logic [7:0] db, input logic [7:0] exp_pc, input logic exp_err);
        PCSrc = pcs; jump = jmp; call = cl; ret = rt; databus = db; advance = 1'b1;
        tick();
        PCSrc = 0; jump = 0; call = 0; ret = 0; databus = 8'h00; advance = 1'b0;
        check("next_pc", currPC, exp_pc);
        check("req_next", imem_req, 1);
        check("valid_clr", instr_valid, 0);
        check("ras_err", ras_err, exp_err);
        model_pc = exp_pc;
    endtask

    // Plain sequential steps from HOLD, ending in HOLD.
    task automatic walk(input int steps);
        for (int i = 0; i < steps; i++) begin
            do_advance(0, 0, 0, 0, 8'h00, model_pc + 8'd1, 0);
            do_fetch(model_pc, 0, model_pc ^ 8'hA5);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {PCSrc, jump, call, ret, advance, imem_ack} = '0;
        databus = 8'h00; imem_data = 8'h00;
        model_pc = 8'h00;
        repeat (2) tick();
        check("rst_req", imem_req, 0);
        check("rst_pc", currPC, 8'h00);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 8'h00);
        check("rst_err", ras_err, 0);
        reset_n = 1'b1;

        // Sequential fetch over the full address space, wrapping FF -> 00.
        for (int i = 0; i < 256; i++) begin
            do_fetch(8'(i), 0, 8'(i) ^ 8'h5A);
            do_advance(0, 0, 0, 0, 8'h00, 8'(i + 1), 0);
        end
        do_fetch(8'h00, 0, 8'h33);

        walk(8'h2A);
        do_advance(1, 0, 0, 0, 8'h05, 8'h2D, 0);
        do_fetch(8'h2D, 0, 8'h11);
        walk(8'hC4 - 8'h2D);
        do_advance(1, 1, 0, 0, 8'h1F, 8'hDF, 0);
        do_fetch(8'hDF, 0, 8'h22);
        do_advance(1, 0, 0, 0, 8'hF8, 8'hD8, 0);
        do_fetch(8'hD8, 0, 8'h44);
        do_advance(0, 1, 0, 0, 8'hE3, 8'hC3, 0);
        do_fetch(8'hC3, 0, 8'h55);

        // Delayed ack; advance while fetching must be ignored.
        do_advance(0, 0, 0, 0, 8'h00, 8'hC4, 0);
        advance = 1'b1; jump = 1'b1;
        tick();
        advance = 1'b0; jump = 1'b0;
        check("adv_in_fetch_pc", currPC, 8'hC4);
        check("adv_in_fetch_req", imem_req, 1);
        do_fetch(8'hC4, 3, 8'h66);

        // Ack while holding must not disturb the held instruction.
        imem_ack = 1'b1; imem_data = 8'hEE;
        tick();
        imem_ack = 1'b0;
        check("ack_in_hold_instr", instr, last_instr);
        check("ack_in_hold_valid", instr_valid, 1);
        check("ack_in_hold_req", imem_req, 0);

        // Asynchronous reset during a fetch wait.
        do_advance(0, 0, 0, 0, 8'h00, 8'hC5, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_pc", currPC, 8'h00);
        check("arst_valid", instr_valid, 0);
        tick();
        reset_n = 1'b1;
        model_pc = 8'h00;
        do_fetch(8'h00, 0, 8'h77);

        walk(8'h10);
`ifdef PC_FETCH_RAS_EN
        do_advance(0, 0, 1, 0, 8'h08, 8'h08, 0);
        do_fetch(8'h08, 0, 8'h01);
        do_advance(0, 0, 0, 1, 8'h00, 8'h11, 0);
        do_fetch(8'h11, 0, 8'h02);
        // Five pushes into four entries: the fifth overwrites the oldest.
        for (int i = 0; i < 5; i++) begin
            do_advance(0, 0, 1, 0, 8'(i), 8'(i), (i == 4) ? 1'b1 : 1'b0);
            check("err_pulse_end", 0, 0) ;
            do_fetch(8'(i), 0, 8'(i + 8'h80));
            check("err_one_cycle", ras_err, 0);
        end
        // call and ret together: the pop wins and nothing is pushed.
        do_advance(0, 0, 1, 1, 8'h1F, 8'h04, 0);
        do_fetch(8'h04, 0, 8'h90);
        do_advance(0, 0, 0, 1, 8'h00, 8'h03, 0);
        do_fetch(8'h03, 0, 8'h91);
        do_advance(0, 0, 0, 1, 8'h00, 8'h02, 0);
        do_fetch(8'h02, 0, 8'h92);
        do_advance(0, 0, 0, 1, 8'h00, 8'h01, 0);
        do_fetch(8'h01, 0, 8'h93);
        do_advance(0, 0, 0, 1, 8'h00, 8'h02, 1);
        do_fetch(8'h02, 0, 8'h94);
        check("err_after_underflow", ras_err, 0);
`else
        do_advance(0, 0, 1, 0, 8'h1F, 8'h11, 0);
        do_fetch(8'h11, 0, 8'h01);
        do_advance(0, 0, 0, 1, 8'h00, 8'h12, 0);
        do_fetch(8'h12, 0, 8'h02);
        do_advance(0, 1, 1, 0, 8'h03, 8'h03, 0);
        do_fetch(8'h03, 0, 8'h03);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
